// File: rtl/slurm32_cpu_memory_port_pkg.sv
// Shared SLURM32 CPU constants: memory-port state encoding and byte-lane
// mask patterns used by the load aligner and the memory port.
package slurm32_cpu_memory_port_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // Byte-lane mask patterns with a defined right-aligned load result
    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

endpackage

// File: rtl/slurm32_load_align.sv
// Combinational load aligner: selects the lanes named by the mask and
// right-aligns them, zero-extending. Unlisted masks pass the enabled lanes
// through in place.
module slurm32_load_align
    import slurm32_cpu_memory_port_pkg::*;
#(
    parameter int BITS = 32
) (
    input  logic [3:0]      mask,
    input  logic [BITS-1:0] rdata,
    output logic [BITS-1:0] data
);

    // Lane select / shift by mask pattern
    always_comb begin
        data = '0;
        case (mask)
            MASK_B0: data[7:0]  = rdata[7:0];
            MASK_B1: data[7:0]  = rdata[15:8];
            MASK_B2: data[7:0]  = rdata[23:16];
            MASK_B3: data[7:0]  = rdata[31:24];
            MASK_H0: data[15:0] = rdata[15:0];
            MASK_H1: data[15:0] = rdata[31:16];
            MASK_W:  data       = rdata;
            default: begin
                for (int i = 0; i < 4; i++)
                    data[8*i +: 8] = rdata[8*i +: 8] & {8{mask[i]}};
            end
        endcase
    end

endmodule

// File: rtl/slurm32_cpu_memory_port.sv
// SLURM32 memory port: one outstanding valid/ack data-bus transaction per
// execute-stage load/store, with timeout abort and aligned load return.
module slurm32_cpu_memory_port
    import slurm32_cpu_memory_port_pkg::*;
#(
    parameter int ADDRESS_BITS   = 32,
    parameter int BITS           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    load_memory,
    input  logic                    store_memory,
    input  logic [ADDRESS_BITS-3:0] load_store_address,
    input  logic [BITS-1:0]         memory_out,
    input  logic [3:0]              memory_mask,
    output logic                    stall,
    output logic [BITS-1:0]         load_data,
    output logic                    load_valid,
    output logic                    bus_error,
    output logic                    bus_req,
    output logic                    bus_wr,
    output logic [ADDRESS_BITS-3:0] bus_addr,
    output logic [BITS-1:0]         bus_wdata,
    output logic [3:0]              bus_wmask,
    input  logic                    bus_ack,
    input  logic [BITS-1:0]         bus_rdata
);

    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

    mem_state_t              state;
    logic [7:0]              cnt;
    logic                    lat_wr;
    logic [ADDRESS_BITS-3:0] lat_addr;
    logic [BITS-1:0]         lat_data;
    logic [3:0]              lat_mask;
    logic [BITS-1:0]         aligned;

    slurm32_load_align #(.BITS(BITS)) u_align (
        .mask  (lat_mask),
        .rdata (bus_rdata),
        .data  (aligned)
    );

    wire busy = (state == ST_WAIT);

    assign stall     = busy;
    assign bus_req   = busy;
    assign bus_wr    = busy & lat_wr;
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_data;
    assign bus_wmask = busy ? lat_mask : 4'b0000;

    // Request capture, bus wait/timeout FSM and registered load return
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_mask   <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_memory || store_memory) begin
                        if (memory_mask == 4'b0000) begin
                            // Empty mask: no bus cycle; a load still completes with zero
                            if (!store_memory) begin
                                load_valid <= 1'b1;
                                load_data  <= '0;
                            end
                        end else begin
                            // Store wins when both are requested
                            lat_wr   <= store_memory;
                            lat_addr <= load_store_address;
                            lat_data <= memory_out;
                            lat_mask <= memory_mask;
                            cnt      <= '0;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus_ack) begin
                        state <= ST_IDLE;
                        if (!lat_wr) begin
                            load_valid <= 1'b1;
                            load_data  <= aligned;
                        end
                    end else if (cnt == TMO) begin
                        state     <= ST_IDLE;
                        bus_error <= 1'b1;
                        if (!lat_wr) begin
                            load_valid <= 1'b1;
                            load_data  <= '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
